// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and helpers for the PCIe TX arbiter: FSM state encoding,
// idle trn values and the round-robin pick function.
package pcie_tx_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic [7:0] TRN_IDLE_TREM_N = 8'hff;
  localparam int         RR_MAX_SRC      = 8;

  // First set bit of req at or after ptr, wrapping at n; returns ptr when req is empty.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] sel;
    logic       found;
    int         c;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_SRC; k++) begin
      c = int'(ptr) + k;
      if (c >= n) c = c - n;
      if (!found && (k < n) && req[c[2:0]]) begin
        sel   = c[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pcie_tx_arb_if.sv
// Source-side handshake plus the trn_* TX bus toward the endpoint core.
// slave = arbiter view, master = sources/core view.
interface pcie_tx_arb_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]       src_req_v;
  logic [NUM_SRC-1:0]       src_req_grant;
  logic                     src_req_stall;
  logic [NUM_SRC-1:0]       src_req_done;
  logic [NUM_SRC-1:0][63:0] src_trn_td;
  logic [NUM_SRC-1:0][7:0]  src_trn_trem_n;
  logic [NUM_SRC-1:0]       src_trn_tsof_n;
  logic [NUM_SRC-1:0]       src_trn_teof_n;
  logic [NUM_SRC-1:0]       src_trn_tsrc_rdy_n;

  logic [63:0]              trn_td;
  logic [7:0]               trn_trem_n;
  logic                     trn_tsof_n;
  logic                     trn_teof_n;
  logic                     trn_tsrc_rdy_n;
  logic                     trn_tdst_rdy_n;
  logic [5:0]               trn_tbuf_av;

  modport slave (
    input  src_req_v, src_req_done, src_trn_td, src_trn_trem_n,
           src_trn_tsof_n, src_trn_teof_n, src_trn_tsrc_rdy_n,
           trn_tdst_rdy_n, trn_tbuf_av,
    output src_req_grant, src_req_stall,
           trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
  );

  modport master (
    output src_req_v, src_req_done, src_trn_td, src_trn_trem_n,
           src_trn_tsof_n, src_trn_teof_n, src_trn_tsrc_rdy_n,
           trn_tdst_rdy_n, trn_tbuf_av,
    input  src_req_grant, src_req_stall,
           trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
  );

endinterface

// File: rtl/pcie_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
// Shared with the TX queue logic.
module pcie_rr_pick #(
  parameter int NUM_SRC  = 3,
  parameter int SRC_BITS = 2
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [SRC_BITS-1:0] ptr,
  output logic                valid,
  output logic [SRC_BITS-1:0] idx
);
  import pcie_tx_arb_pkg::*;

  logic [RR_MAX_SRC-1:0] req_ext;

  genvar gi;
  generate
    for (gi = 0; gi < RR_MAX_SRC; gi++) begin : g_req_ext
      if (gi < NUM_SRC) begin : g_live
        assign req_ext[gi] = req[gi];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign valid = |req;
  assign idx   = SRC_BITS'(rr_pick(req_ext, 3'(ptr), NUM_SRC));

endmodule

// File: rtl/pcie_tx_arb.sv
// Round-robin arbiter of NUM_SRC TLP sources onto one PCIe trn_* TX bus, grant held per TLP.
// Optional BUSY watchdog enabled by `define PCIE_TX_ARB_WDOG_EN.
module pcie_tx_arb #(
  parameter int NUM_SRC     = 3,
  parameter int SRC_BITS    = 2,
  parameter int MIN_BUF_AV  = 1,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic           pcie_clk,
  input  logic           rst_n,
  pcie_tx_arb_if.slave   bus,
  output logic           err_wdog
);
  import pcie_tx_arb_pkg::*;

  localparam logic [0:0]          ST_IDLE      = ARB_IDLE;
  localparam logic [0:0]          ST_BUSY      = ARB_BUSY;
  localparam logic [5:0]          MIN_BUF_AV_W = 6'(MIN_BUF_AV);
  localparam logic [SRC_BITS-1:0] LAST_SRC     = SRC_BITS'(NUM_SRC - 1);

  generate
    if (NUM_SRC < 2 || NUM_SRC > RR_MAX_SRC || SRC_BITS != $clog2(NUM_SRC) || WDOG_CYCLES < 2) begin : g_bad_params
      $error("pcie_tx_arb: illegal parameter set");
    end
  endgenerate

  logic [0:0]          state_reg, state_next;
  logic [NUM_SRC-1:0]  grant_reg, grant_next;
  logic [SRC_BITS-1:0] gidx_reg, gidx_next;
  logic [SRC_BITS-1:0] ptr_reg, ptr_next;
  logic [SRC_BITS-1:0] ptr_after;
  logic [SRC_BITS-1:0] pick_idx;
  logic                pick_valid;
  logic                busy;
  logic                done_fire;
  logic                wdog_fire;

  pcie_rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .SRC_BITS (SRC_BITS)
  ) u_pick (
    .req   (bus.src_req_v),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy      = (state_reg == ST_BUSY);
  // A done beat only counts when the core actually accepts it.
  assign done_fire = busy && bus.src_req_done[gidx_reg] && !bus.trn_tdst_rdy_n;
  assign ptr_after = (gidx_reg == LAST_SRC) ? '0 : gidx_reg + 1'b1;

`ifdef PCIE_TX_ARB_WDOG_EN
  localparam int                   WDOG_BITS = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_BITS-1:0] WDOG_LAST = WDOG_BITS'(WDOG_CYCLES - 1);

  logic [WDOG_BITS-1:0] wdog_cnt_reg;
  logic                 err_reg;

  // Held at zero while idle, so it starts from zero on every grant.
  always_ff @(posedge pcie_clk) begin
    if (!rst_n) begin
      wdog_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      wdog_cnt_reg <= busy ? wdog_cnt_reg + 1'b1 : '0;
      if (wdog_fire) err_reg <= 1'b1;
    end
  end

  assign wdog_fire = busy && !done_fire && (wdog_cnt_reg == WDOG_LAST);
  assign err_wdog  = err_reg;
`else
  assign wdog_fire = 1'b0;
  assign err_wdog  = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid && (bus.trn_tbuf_av >= MIN_BUF_AV_W)) begin
          state_next = ST_BUSY;
          gidx_next  = pick_idx;
          grant_next = NUM_SRC'(1) << pick_idx;
        end
      end
      default: begin
        if (done_fire || wdog_fire) begin
          state_next = ST_IDLE;
          grant_next = '0;
          ptr_next   = ptr_after;
        end
      end
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign bus.src_req_grant = grant_reg;
  assign bus.src_req_stall = bus.trn_tdst_rdy_n;

  always_comb begin
    bus.trn_td         = '0;
    bus.trn_trem_n     = TRN_IDLE_TREM_N;
    bus.trn_tsof_n     = 1'b1;
    bus.trn_teof_n     = 1'b1;
    bus.trn_tsrc_rdy_n = 1'b1;
    if (busy) begin
      bus.trn_td         = bus.src_trn_td[gidx_reg];
      bus.trn_trem_n     = bus.src_trn_trem_n[gidx_reg];
      bus.trn_tsof_n     = bus.src_trn_tsof_n[gidx_reg];
      bus.trn_teof_n     = bus.src_trn_teof_n[gidx_reg];
      bus.trn_tsrc_rdy_n = bus.src_trn_tsrc_rdy_n[gidx_reg];
    end
  end

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Self-checking bench for pcie_tx_arb: directed scenarios plus randomized traffic,
// checked every cycle against a queue-free ownership model of the arbiter.
module tb_pcie_tx_arb;

  localparam int N        = 3;
  localparam int MIN_BUF  = 1;
  localparam int WDOG     = 16;

  logic pcie_clk = 1'b0;
  logic rst_n    = 1'b0;
  logic err_wdog;

  always #5 pcie_clk = ~pcie_clk;

  pcie_tx_arb_if #(.NUM_SRC(N)) bus ();

  pcie_tx_arb #(
    .NUM_SRC     (N),
    .SRC_BITS    (2),
    .MIN_BUF_AV  (MIN_BUF),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .pcie_clk (pcie_clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_wdog (err_wdog)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which source owns the bus (-1 = none), next-priority source, cycles owned.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_err   = 1'b0;
  bit m_ok    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare on the falling edge, model advance on the rising edge.
  initial begin
    forever begin
      @(negedge pcie_clk);
      if (m_ok) begin
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk("grant", 64'(bus.src_req_grant), 64'(eg));
        chk("stall", 64'(bus.src_req_stall), 64'(bus.trn_tdst_rdy_n));
        chk("err_wdog", 64'(err_wdog), 64'(m_err));
        if (m_owner >= 0) begin
          chk("trn_td", bus.trn_td, bus.src_trn_td[m_owner]);
          chk("trn_trem_n", 64'(bus.trn_trem_n), 64'(bus.src_trn_trem_n[m_owner]));
          chk("trn_tsof_n", 64'(bus.trn_tsof_n), 64'(bus.src_trn_tsof_n[m_owner]));
          chk("trn_teof_n", 64'(bus.trn_teof_n), 64'(bus.src_trn_teof_n[m_owner]));
          chk("trn_tsrc_rdy_n", 64'(bus.trn_tsrc_rdy_n), 64'(bus.src_trn_tsrc_rdy_n[m_owner]));
        end else begin
          chk("idle_td", bus.trn_td, 64'd0);
          chk("idle_trem_n", 64'(bus.trn_trem_n), 64'hff);
          chk("idle_sof_eof_rdy", 64'({bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}), 64'h7);
        end
      end
      @(posedge pcie_clk);
      if (!rst_n) begin
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_err   = 1'b0;
        m_ok    = 1'b1;
      end else if (m_owner < 0) begin
        if (bus.src_req_v != '0 && int'(bus.trn_tbuf_av) >= MIN_BUF) begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_owner < 0 && bus.src_req_v[c]) m_owner = c;
          end
          m_held = 0;
        end
      end else if (bus.src_req_done[m_owner] && !bus.trn_tdst_rdy_n) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
`ifdef PCIE_TX_ARB_WDOG_EN
        m_held++;
        if (m_held == WDOG) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_err   = 1'b1;
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      bus.src_trn_td[i]         = {$urandom(), $urandom()};
      bus.src_trn_trem_n[i]     = 8'($urandom());
      bus.src_trn_tsof_n[i]     = 1'($urandom());
      bus.src_trn_teof_n[i]     = 1'($urandom());
      bus.src_trn_tsrc_rdy_n[i] = 1'($urandom());
    end
  endtask

  task automatic idle_inputs();
    rand_data();
    bus.src_req_v      = '0;
    bus.src_req_done   = '0;
    bus.trn_tdst_rdy_n = 1'b0;
    bus.trn_tbuf_av    = 6'd8;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] d0;
    logic [2:0]  order [6];
    int          held;

    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;

    // Reset state with busy-looking source data present.
    do_reset();
    bus.src_trn_tsrc_rdy_n = '0;
    #1;
    chk("rst_grant", 64'(bus.src_req_grant), 64'd0);
    chk("rst_td", bus.trn_td, 64'd0);
    chk("rst_trem_n", 64'(bus.trn_trem_n), 64'hff);
    chk("rst_src_rdy_n", 64'(bus.trn_tsrc_rdy_n), 64'd1);
    chk("rst_err", 64'(err_wdog), 64'd0);

    // Single source, 2-beat TLP.
    d0 = 64'h0123_4567_89ab_cdef;
    bus.src_req_v = 3'b001;
    bus.src_trn_td[0] = d0;
    bus.src_trn_tsof_n[0] = 1'b0;
    bus.src_trn_teof_n[0] = 1'b1;
    tick();
    chk("single_grant", 64'(bus.src_req_grant), 64'h1);
    chk("single_td_beat1", bus.trn_td, d0);
    chk("single_sof", 64'(bus.trn_tsof_n), 64'd0);
    bus.src_req_v = '0;
    bus.src_trn_tsof_n[0] = 1'b1;
    bus.src_trn_teof_n[0] = 1'b0;
    bus.src_req_done = 3'b001;
    #1;
    chk("single_eof", 64'(bus.trn_teof_n), 64'd0);
    tick();
    bus.src_req_done = '0;
    chk("single_release", 64'(bus.src_req_grant), 64'd0);
    bus.src_req_v = 3'b011;
    tick();
    chk("ptr_after_src0", 64'(bus.src_req_grant), 64'h2);
    bus.src_req_v = '0;
    bus.src_req_done = 3'b010;
    tick();
    bus.src_req_done = '0;

    // All request continuously: strict rotation, one idle cycle between TLPs.
    do_reset();
    bus.src_req_v = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_order_%0d", k), 64'(bus.src_req_grant), 64'(order[k]));
      bus.src_req_done = bus.src_req_grant;
      tick();
      chk($sformatf("rr_gap_%0d", k), 64'(bus.src_req_grant), 64'd0);
      bus.src_req_done = '0;
    end
    bus.src_req_v = '0;

    // Stall during EOF beat with done asserted.
    do_reset();
    bus.src_req_v = 3'b001;
    tick();
    bus.src_req_v = '0;
    bus.src_trn_teof_n[0] = 1'b0;
    bus.src_req_done = 3'b001;
    bus.trn_tdst_rdy_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_grant_%0d", k), 64'(bus.src_req_grant), 64'h1);
      chk($sformatf("stall_flag_%0d", k), 64'(bus.src_req_stall), 64'd1);
      chk($sformatf("stall_eof_%0d", k), 64'(bus.trn_teof_n), 64'd0);
    end
    bus.trn_tdst_rdy_n = 1'b0;
    #1;
    chk("stall_release_flag", 64'(bus.src_req_stall), 64'd0);
    tick();
    chk("stall_release_grant", 64'(bus.src_req_grant), 64'd0);
    bus.src_req_done = '0;

    // No TX buffers: no grant until tbuf_av reaches the minimum.
    do_reset();
    bus.trn_tbuf_av = 6'd0;
    bus.src_req_v = 3'b111;
    tick();
    chk("tbuf0_a", 64'(bus.src_req_grant), 64'd0);
    tick();
    chk("tbuf0_b", 64'(bus.src_req_grant), 64'd0);
    bus.trn_tbuf_av = 6'd1;
    tick();
    chk("tbuf1_grant", 64'(bus.src_req_grant), 64'h1);
    bus.src_req_v = '0;
    bus.src_req_done = 3'b001;
    tick();
    bus.src_req_done = '0;

    // Reset in the middle of a TLP owned by src1.
    do_reset();
    bus.src_req_v = 3'b010;
    bus.src_trn_tsrc_rdy_n = '0;
    bus.src_trn_trem_n[1] = 8'h0f;
    tick();
    chk("midrst_grant_before", 64'(bus.src_req_grant), 64'h2);
    rst_n = 1'b0;
    tick();
    chk("midrst_grant", 64'(bus.src_req_grant), 64'd0);
    chk("midrst_src_rdy_n", 64'(bus.trn_tsrc_rdy_n), 64'd1);
    chk("midrst_trem_n", 64'(bus.trn_trem_n), 64'hff);
    rst_n = 1'b1;
    bus.src_req_v = 3'b111;
    tick();
    chk("midrst_next_src0", 64'(bus.src_req_grant), 64'h1);
    bus.src_req_v = '0;
    bus.src_req_done = 3'b001;
    tick();
    bus.src_req_done = '0;

    // src2 granted and never finishes.
    do_reset();
    bus.src_req_v = 3'b100;
    tick();
    chk("hang_grant", 64'(bus.src_req_grant), 64'h4);
    bus.src_req_v = '0;
    held = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.src_req_grant == 3'b100) held++;
      else break;
    end
`ifdef PCIE_TX_ARB_WDOG_EN
    chk("wdog_busy_cycles", 64'(held), 64'(WDOG));
    chk("wdog_err", 64'(err_wdog), 64'd1);
    bus.src_req_v = 3'b111;
    tick();
    chk("wdog_next_src0", 64'(bus.src_req_grant), 64'h1);
    bus.src_req_v = '0;
    bus.src_req_done = 3'b001;
    tick();
    bus.src_req_done = '0;
    tick();
    chk("wdog_err_sticky", 64'(err_wdog), 64'd1);
`else
    chk("hold_busy_cycles", 64'(held), 64'd41);
    chk("hold_no_err", 64'(err_wdog), 64'd0);
    bus.src_req_done = 3'b100;
    tick();
    bus.src_req_done = '0;
    chk("hold_released", 64'(bus.src_req_grant), 64'd0);
`endif

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      rand_data();
      bus.src_req_v = 3'($urandom());
      for (int i = 0; i < N; i++) bus.src_req_done[i] = ($urandom_range(0, 2) == 0);
      bus.trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
      bus.trn_tbuf_av = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
